// File: rtl/sd_xfer_pkg.sv
// Shared constants for the SD multi-block transfer sequencer: FSM state codes,
// start[1:0] handshake encodings toward sd_data_serial_host, and the read-retry limit.
package sd_xfer_pkg;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] START    = 3'd1;
    localparam logic [2:0] WAIT_FIN = 3'd2;
    localparam logic [2:0] RELEASE  = 3'd3;
    localparam logic [2:0] GAP      = 3'd4;
    localparam logic [2:0] ABORT    = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;

    localparam logic [1:0] START_IDLE  = 2'b00;
    localparam logic [1:0] START_WR    = 2'b01;
    localparam logic [1:0] START_RD    = 2'b10;
    localparam logic [1:0] START_ABORT = 2'b11;

    localparam logic [1:0] MAX_RETRY = 2'd2;

endpackage

// File: rtl/sd_xfer_gap_timer.sv
// Loadable down-counter with a zero flag; times the idle gap between blocks.
module sd_xfer_gap_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sd_data_xfer_ctrl.sv
// Multi-block transfer sequencer driving the sd_data_serial_host start[1:0] handshake.
// Optional read-CRC retry is enabled by defining SD_XFER_READ_RETRY_EN.
module sd_data_xfer_ctrl
    import sd_xfer_pkg::*;
#(
    parameter int BLKCNT_W   = 16,
    parameter int GAP_CYCLES = 8
) (
    input  logic                sd_clk,
    input  logic                rst,
    input  logic                req_i,
    input  logic                dir_i,
    input  logic [BLKCNT_W-1:0] blkcnt_i,
    input  logic                abort_i,
    input  logic [31:0]         timeout_i,
    output logic [1:0]          start_o,
    input  logic                finish_i,
    input  logic                crc_ok_i,
    input  logic [31:0]         wait_reg_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [BLKCNT_W-1:0] blks_done_o,
    output logic                crc_err_o,
    output logic                tmo_err_o,
    output logic                aborted_o
`ifdef SD_XFER_READ_RETRY_EN
    ,
    output logic [1:0]          retry_cnt_o
`endif
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    // The GAP state lasts exactly GAP_CYCLES cycles, so the counter starts one below.
    localparam logic [GAP_W-1:0]    GAP_LOAD = GAP_W'(GAP_CYCLES - 1);
    localparam logic [BLKCNT_W-1:0] BLK_MAX  = '1;
    localparam logic [BLKCNT_W-1:0] BLK_ONE  = BLKCNT_W'(1);

    logic [2:0]          state_q, state_d;
    logic                dir_q, dir_d;
    logic [BLKCNT_W-1:0] blkcnt_q, blkcnt_d;
    logic [BLKCNT_W-1:0] blks_done_q, blks_done_d;
    logic [1:0]          start_q, start_d;
    logic                crc_err_q, crc_err_d;
    logic                tmo_err_q, tmo_err_d;
    logic                aborted_q, aborted_d;
    logic                abort_ph_q, abort_ph_d;
`ifdef SD_XFER_READ_RETRY_EN
    logic [1:0]          retry_cnt_q, retry_cnt_d;
    logic [1:0]          blk_retry_q, blk_retry_d;
    logic                retry_pend_q, retry_pend_d;
`endif

    logic                gap_load, gap_dec, gap_zero;
    logic                abort_hit;
    logic [BLKCNT_W-1:0] blks_inc;

    sd_xfer_gap_timer #(.W(GAP_W)) u_gap_timer (
        .clk        (sd_clk),
        .rst        (rst),
        .load_i     (gap_load),
        .load_val_i (GAP_LOAD),
        .dec_i      (gap_dec),
        .zero_o     (gap_zero)
    );

    assign abort_hit = abort_i && (state_q inside {START, WAIT_FIN, RELEASE, GAP});
    assign blks_inc  = (blks_done_q == BLK_MAX) ? blks_done_q : blks_done_q + BLK_ONE;

    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        blkcnt_d    = blkcnt_q;
        blks_done_d = blks_done_q;
        start_d     = start_q;
        crc_err_d   = crc_err_q;
        tmo_err_d   = tmo_err_q;
        aborted_d   = aborted_q;
        abort_ph_d  = abort_ph_q;
`ifdef SD_XFER_READ_RETRY_EN
        retry_cnt_d  = retry_cnt_q;
        blk_retry_d  = blk_retry_q;
        retry_pend_d = retry_pend_q;
`endif
        gap_load = 1'b0;
        gap_dec  = 1'b0;

        // Abort wins over everything, including a finish in the same cycle.
        if (abort_hit) begin
            state_d    = ABORT;
            start_d    = START_ABORT;
            abort_ph_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i) begin
                        dir_d       = dir_i;
                        blkcnt_d    = (blkcnt_i == '0) ? BLK_ONE : blkcnt_i;
                        blks_done_d = '0;
                        crc_err_d   = 1'b0;
                        tmo_err_d   = 1'b0;
                        aborted_d   = 1'b0;
`ifdef SD_XFER_READ_RETRY_EN
                        retry_cnt_d  = 2'd0;
                        blk_retry_d  = 2'd0;
                        retry_pend_d = 1'b0;
`endif
                        state_d = START;
                    end
                end
                START: begin
                    start_d = dir_q ? START_RD : START_WR;
                    state_d = WAIT_FIN;
                end
                WAIT_FIN: begin
                    if (finish_i) begin
                        start_d = START_IDLE;
                        state_d = RELEASE;
                        if (dir_q && (wait_reg_i >= timeout_i)) begin
                            tmo_err_d = 1'b1;
                        end else if (dir_q && !crc_ok_i) begin
`ifdef SD_XFER_READ_RETRY_EN
                            if (blk_retry_q < MAX_RETRY) begin
                                retry_pend_d = 1'b1;
                                blk_retry_d  = blk_retry_q + 2'd1;
                                if (retry_cnt_q != 2'b11) begin
                                    retry_cnt_d = retry_cnt_q + 2'd1;
                                end
                            end else begin
                                crc_err_d = 1'b1;
                            end
`else
                            crc_err_d = 1'b1;
`endif
                        end else begin
                            blks_done_d = blks_inc;
`ifdef SD_XFER_READ_RETRY_EN
                            blk_retry_d = 2'd0;
`endif
                        end
                    end
                end
                RELEASE: begin
                    if (!finish_i) begin
                        if (crc_err_q || tmo_err_q) begin
                            state_d = DONE;
`ifdef SD_XFER_READ_RETRY_EN
                        end else if (retry_pend_q) begin
                            retry_pend_d = 1'b0;
                            gap_load     = 1'b1;
                            state_d      = GAP;
`endif
                        end else if (blks_done_q == blkcnt_q) begin
                            state_d = DONE;
                        end else begin
                            gap_load = 1'b1;
                            state_d  = GAP;
                        end
                    end
                end
                GAP: begin
                    if (gap_zero) begin
                        state_d = START;
                    end else begin
                        gap_dec = 1'b1;
                    end
                end
                ABORT: begin
                    start_d = START_IDLE;
                    if (!abort_ph_q) begin
                        abort_ph_d = 1'b1;
                    end else begin
                        abort_ph_d = 1'b0;
                        aborted_d  = 1'b1;
                        state_d    = DONE;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                    start_d = START_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sd_clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dir_q       <= 1'b0;
            blkcnt_q    <= '0;
            blks_done_q <= '0;
            start_q     <= START_IDLE;
            crc_err_q   <= 1'b0;
            tmo_err_q   <= 1'b0;
            aborted_q   <= 1'b0;
            abort_ph_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            blkcnt_q    <= blkcnt_d;
            blks_done_q <= blks_done_d;
            start_q     <= start_d;
            crc_err_q   <= crc_err_d;
            tmo_err_q   <= tmo_err_d;
            aborted_q   <= aborted_d;
            abort_ph_q  <= abort_ph_d;
        end
    end

`ifdef SD_XFER_READ_RETRY_EN
    always_ff @(posedge sd_clk) begin
        if (rst) begin
            retry_cnt_q  <= 2'd0;
            blk_retry_q  <= 2'd0;
            retry_pend_q <= 1'b0;
        end else begin
            retry_cnt_q  <= retry_cnt_d;
            blk_retry_q  <= blk_retry_d;
            retry_pend_q <= retry_pend_d;
        end
    end

    assign retry_cnt_o = retry_cnt_q;
`endif

    assign start_o     = start_q;
    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign blks_done_o = blks_done_q;
    assign crc_err_o   = crc_err_q;
    assign tmo_err_o   = tmo_err_q;
    assign aborted_o   = aborted_q;

endmodule

// File: tb/tb_sd_data_xfer_ctrl.sv
// Scoreboard bench for sd_data_xfer_ctrl with a behavioural serial-host model.
// Expected transfer results are queued at request time and checked on done_o.
module tb_sd_data_xfer_ctrl;

    localparam int BLKCNT_W   = 16;
    localparam int GAP_CYCLES = 8;

    logic                sd_clk;
    logic                rst;
    logic                req_i;
    logic                dir_i;
    logic [BLKCNT_W-1:0] blkcnt_i;
    logic                abort_i;
    logic [31:0]         timeout_i;
    logic [1:0]          start_o;
    logic                finish_i;
    logic                crc_ok_i;
    logic [31:0]         wait_reg_i;
    logic                busy_o;
    logic                done_o;
    logic [BLKCNT_W-1:0] blks_done_o;
    logic                crc_err_o;
    logic                tmo_err_o;
    logic                aborted_o;
`ifdef SD_XFER_READ_RETRY_EN
    logic [1:0]          retryCnt;
`endif

    sd_data_xfer_ctrl #(.BLKCNT_W(BLKCNT_W), .GAP_CYCLES(GAP_CYCLES)) dut (
        .sd_clk      (sd_clk),
        .rst         (rst),
        .req_i       (req_i),
        .dir_i       (dir_i),
        .blkcnt_i    (blkcnt_i),
        .abort_i     (abort_i),
        .timeout_i   (timeout_i),
        .start_o     (start_o),
        .finish_i    (finish_i),
        .crc_ok_i    (crc_ok_i),
        .wait_reg_i  (wait_reg_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .blks_done_o (blks_done_o),
        .crc_err_o   (crc_err_o),
        .tmo_err_o   (tmo_err_o),
        .aborted_o   (aborted_o)
`ifdef SD_XFER_READ_RETRY_EN
        ,
        .retry_cnt_o (retryCnt)
`endif
    );

    typedef struct {
        int blks;
        bit crc;
        bit tmo;
        bit abrt;
        int starts;
        int retries;
    } exp_t;

    exp_t expQ[$];

    int testsRun    = 0;
    int testsFailed = 0;
    int cycleCount  = 0;
    int finishFallCycle = 0;
    int startCount  = 0;
    int doneSeen    = 0;
    int abortRun    = 0;
    int hostDelay   = 10;
    int hostCrcFails = 0;
    bit hostTmo     = 0;
    logic [1:0] prevStart = 2'b00;
    logic       prevDone  = 1'b0;

    initial sd_clk = 1'b0;
    always #5 sd_clk = ~sd_clk;

    always @(posedge sd_clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Serial host model: answers each block start after hostDelay cycles.
    initial begin
        logic [1:0] curStart;
        int guard;
        finish_i   = 1'b0;
        crc_ok_i   = 1'b1;
        wait_reg_i = 32'd0;
        forever begin
            @(negedge sd_clk);
            if (!rst && (start_o == 2'b01 || start_o == 2'b10)) begin
                curStart = start_o;
                repeat (hostDelay) @(negedge sd_clk);
                if (start_o == curStart) begin
                    if (curStart == 2'b10 && hostCrcFails > 0) begin
                        crc_ok_i = 1'b0;
                        hostCrcFails--;
                    end else begin
                        crc_ok_i = 1'b1;
                    end
                    wait_reg_i = hostTmo ? timeout_i : 32'd0;
                    finish_i   = 1'b1;
                    guard = 0;
                    do begin
                        @(negedge sd_clk);
                        guard++;
                    end while (start_o != 2'b00 && guard < 50);
                    finish_i = 1'b0;
                    crc_ok_i = 1'b1;
                    finishFallCycle = cycleCount;
                end
            end
        end
    end

    // Output monitor: start/abort sequencing and the done-time scoreboard pop.
    always @(negedge sd_clk) begin
        if (!rst) begin
            if ((start_o == 2'b01 || start_o == 2'b10) && prevStart != start_o) begin
                startCount++;
                if (startCount > 1)
                    checkOutput("gap_latency", cycleCount - finishFallCycle, GAP_CYCLES + 2);
            end
            if (start_o == 2'b11) begin
                abortRun++;
            end else if (abortRun != 0) begin
                checkOutput("abort_len", abortRun, 1);
                checkOutput("abort_then_idle", start_o, 0);
                abortRun = 0;
            end
            if (done_o) begin
                if (prevDone) checkOutput("done_width", 2, 1);
                doneSeen++;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_done", 1, 0);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    checkOutput("blks_done", blks_done_o, e.blks);
                    checkOutput("crc_err", crc_err_o, e.crc);
                    checkOutput("tmo_err", tmo_err_o, e.tmo);
                    checkOutput("aborted", aborted_o, e.abrt);
                    checkOutput("start_count", startCount, e.starts);
`ifdef SD_XFER_READ_RETRY_EN
                    checkOutput("retry_cnt", retryCnt, e.retries);
`endif
                end
            end
        end
        prevStart = start_o;
        prevDone  = done_o;
    end

    task automatic applyStimulus(input bit dir, input int blk, input int dly, input int crcFails,
                                 input bit tmo, input int abortAt, input bit poke,
                                 input int expBlks, input int expStarts, input bit expCrc,
                                 input bit expTmo, input bit expAbrt, input int expRetries);
        exp_t e;
        int target;
        int guard;
        hostDelay    = dly;
        hostCrcFails = crcFails;
        hostTmo      = tmo;
        e.blks = expBlks; e.crc = expCrc; e.tmo = expTmo; e.abrt = expAbrt;
        e.starts = expStarts; e.retries = expRetries;
        expQ.push_back(e);
        target     = doneSeen + 1;
        startCount = 0;
        @(negedge sd_clk);
        req_i    = 1'b1;
        dir_i    = dir;
        blkcnt_i = BLKCNT_W'(blk);
        @(negedge sd_clk);
        req_i = 1'b0;
        checkOutput("lat1_start", start_o, 0);
        checkOutput("accept_busy", busy_o, 1);
        checkOutput("accept_blks", blks_done_o, 0);
        checkOutput("accept_flags", {crc_err_o, tmo_err_o, aborted_o}, 0);
        @(negedge sd_clk);
        checkOutput("lat2_start", start_o, dir ? 2 : 1);
        if (poke) begin
            repeat (3) @(negedge sd_clk);
            checkOutput("poke_busy", busy_o, 1);
            req_i    = 1'b1;
            dir_i    = ~dir;
            blkcnt_i = BLKCNT_W'(7);
            @(negedge sd_clk);
            req_i = 1'b0;
        end
        if (abortAt > 0) begin
            guard = 0;
            while (startCount < abortAt && guard < 2000) begin
                @(negedge sd_clk);
                guard++;
            end
            repeat (5) @(negedge sd_clk);
            abort_i = 1'b1;
            @(negedge sd_clk);
            abort_i = 1'b0;
        end
        guard = 0;
        while (doneSeen < target && guard < 3000) begin
            @(negedge sd_clk);
            guard++;
        end
        if (doneSeen < target) checkOutput("done_timeout", 0, 1);
        repeat (3) @(negedge sd_clk);
        checkOutput("idle_after", busy_o, 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        req_i     = 1'b0;
        dir_i     = 1'b0;
        blkcnt_i  = '0;
        abort_i   = 1'b0;
        timeout_i = 32'd1000;
        repeat (3) @(negedge sd_clk);
        rst = 1'b0;
        @(negedge sd_clk);
        checkOutput("rst_start", start_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_done", done_o, 0);
        checkOutput("rst_blks", blks_done_o, 0);
        checkOutput("rst_flags", {crc_err_o, tmo_err_o, aborted_o}, 0);

        // abort in IDLE is ignored
        abort_i = 1'b1;
        @(negedge sd_clk);
        abort_i = 1'b0;
        @(negedge sd_clk);
        checkOutput("idle_abort_start", start_o, 0);
        checkOutput("idle_abort_flag", aborted_o, 0);

        // write, 3 blocks, clean
        applyStimulus(1'b0, 3, 100, 0, 1'b0, 0, 1'b0, 3, 3, 1'b0, 1'b0, 1'b0, 0);
`ifdef SD_XFER_READ_RETRY_EN
        // read, CRC keeps failing: two retries then error
        applyStimulus(1'b1, 2, 20, 3, 1'b0, 0, 1'b0, 0, 3, 1'b1, 1'b0, 1'b0, 2);
`else
        // read, first block fails CRC
        applyStimulus(1'b1, 2, 20, 1, 1'b0, 0, 1'b0, 0, 1, 1'b1, 1'b0, 1'b0, 0);
`endif
        // read timeout at wait_reg == timeout
        timeout_i = 32'd50;
        applyStimulus(1'b1, 4, 20, 0, 1'b1, 0, 1'b0, 0, 1, 1'b0, 1'b1, 1'b0, 0);
        timeout_i = 32'd1000;
        // abort during WAIT_FIN of block 2 of 5
        applyStimulus(1'b0, 5, 40, 0, 1'b0, 2, 1'b0, 1, 2, 1'b0, 1'b0, 1'b1, 0);
        // blkcnt 0 acts as 1; a request while busy is ignored
        applyStimulus(1'b0, 0, 10, 0, 1'b0, 0, 1'b1, 1, 1, 1'b0, 1'b0, 1'b0, 0);
        // clean two-block read
        applyStimulus(1'b1, 2, 15, 0, 1'b0, 0, 1'b0, 2, 2, 1'b0, 1'b0, 1'b0, 0);
`ifdef SD_XFER_READ_RETRY_EN
        // CRC fails twice then passes
        applyStimulus(1'b1, 1, 12, 2, 1'b0, 0, 1'b0, 1, 3, 1'b0, 1'b0, 1'b0, 2);
`endif
        checkOutput("sb_empty", expQ.size(), 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/sd_data_xfer_ctrl.md
Name: sd_data_xfer_ctrl

Overview:
- Multi-block transfer sequencer that sits directly upstream of sd_data_serial_host and drives its start[1:0] handshake.
- Accepts one transfer request (direction plus block count) from the controller register / command layer.
- Per block: issues single-block starts, waits for finish, releases start, and enforces an inter-block gap.
- Accumulates CRC and timeout status and reports completion; supports abort at any point.

Parameters:
- BLKCNT_W, 16, width of block count and blocks-done counter.
- GAP_CYCLES, 8, idle sd_clk cycles inserted between consecutive blocks (minimum 1).

Ports:
- sd_clk  in  1  single clock, shared with the serial host.
- rst  in  1  synchronous, active-high reset.
- req_i  in  1  one-cycle transfer request; accepted only in IDLE.
- dir_i  in  1  0 = write, 1 = read; sampled with req_i.
- blkcnt_i  in  BLKCNT_W  number of blocks; sampled with req_i; 0 is treated as 1.
- abort_i  in  1  abort request; level or pulse.
- timeout_i  in  32  read start-bit timeout; compared against wait_reg_i.
- start_o  out  2  to host: 00 idle, 01 write, 10 read, 11 abort.
- finish_i  in  1  from host finish_o.
- crc_ok_i  in  1  from host crc_ok.
- wait_reg_i  in  32  from host wait_reg_o.
- busy_o  out  1  high in every state except IDLE.
- done_o  out  1  one-cycle pulse when a transfer ends (normal, error or abort).
- blks_done_o  out  BLKCNT_W  blocks completed in the current or last transfer.
- crc_err_o  out  1  sticky: a read block failed CRC; cleared on next accepted req_i.
- tmo_err_o  out  1  sticky: a read start bit timed out; cleared on next accepted req_i.
- aborted_o  out  1  sticky: last transfer was aborted; cleared on next accepted req_i.

Behaviour:
- Reset: all outputs 0, start_o = 00, state IDLE, internal counters 0.
- IDLE:
  - On req_i, latch dir and blkcnt (0 becomes 1), clear blks_done_o and the sticky flags, then go to START.
  - req_i in any other state is ignored.
- START: start_o = 01 (write) or 10 (read); go to WAIT_FIN the next cycle.
- WAIT_FIN:
  - Hold start_o until finish_i = 1.
  - Read: if wait_reg_i >= timeout_i, set tmo_err_o. Otherwise, if crc_ok_i = 0, set crc_err_o.
  - Increment blks_done_o only when there is no error.
  - Go to RELEASE.
- RELEASE:
  - start_o = 00; wait until finish_i = 0, which confirms the host has returned to IDLE.
  - Then: on error, go to DONE (stop on first error). If blks_done_o == latched count, go to DONE. Otherwise load the gap counter with GAP_CYCLES and go to GAP.
- GAP: start_o = 00; decrement the counter; at 0 go to START.
- DONE: pulse done_o for one cycle; return to IDLE.
- ABORT:
  - abort_i in any non-IDLE state drives start_o = 11 for exactly one cycle, then 00 for one cycle.
  - Then set aborted_o, pulse done_o and return to IDLE.
  - abort_i takes priority over finish_i in the same cycle.
  - abort_i in IDLE is ignored.
- Latency:
  - req_i to first start_o change: 2 cycles.
  - finish_i low to next start_o: GAP_CYCLES + 2 cycles.
- blks_done_o saturates at 2^BLKCNT_W − 1; it never wraps.
- Reset mid-transfer: start_o goes to 00 in the same edge; the host is expected to see rst too.

Optional Feature:
- Macro: SD_XFER_READ_RETRY_EN.
- Enabled:
  - A read block with a CRC error is re-issued up to 2 times before crc_err_o is set.
  - A retry re-enters START after GAP; blks_done_o does not advance.
  - Adds a retry_cnt_o output, 2 bits, holding the total retries for the transfer, cleared on req_i.
- Disabled: no retry and no retry_cnt_o port; first error ends the transfer.

Decomposition:
- Package sd_xfer_pkg:
  - state enum (IDLE, START, WAIT_FIN, RELEASE, GAP, ABORT, DONE).
  - start encodings START_IDLE = 2'b00, START_WR = 2'b01, START_RD = 2'b10, START_ABORT = 2'b11.
  - MAX_RETRY = 2.
- One sub-module is natural: sd_xfer_gap_timer, a loadable down-counter with a zero flag.

Test Plan:
- Write, blkcnt 3, host model finishes after 100 cycles each → start_o shows 01 three times, each separated by ≥ GAP_CYCLES cycles of 00; done_o pulses once; blks_done_o = 3; no flags.
- Read, blkcnt 2, crc_ok_i = 0 on block 1 → stops after block 1; crc_err_o = 1; blks_done_o = 0; done_o pulses; no second start.
- Read, blkcnt 4, timeout_i = 50, host finishes with wait_reg_i = 50 → tmo_err_o = 1; blks_done_o = 0.
- abort_i in WAIT_FIN of block 2 of 5 → start_o = 11 for one cycle, then 00; aborted_o = 1; blks_done_o = 1.
- blkcnt_i = 0 → exactly one block transferred; req_i while busy is ignored; a new req_i clears the sticky flags.
- SD_XFER_READ_RETRY_EN: CRC fails twice then passes → 3 read starts; crc_err_o = 0; retry_cnt_o = 2; blks_done_o = 1.
